// File: rtl/can_mac_pkg.sv
// Shared CAN MAC types: confirm status, frame record and queue FSM encoding.
// Used by the transmit queue and its frame FIFO.
package can_mac_pkg;

  localparam int CAN_ID_W    = 11;
  localparam int CAN_MAX_DLC = 8;
  localparam int CAN_DATA_W  = 64;

  typedef enum logic {
    Success = 1'b0,
    Fail    = 1'b1
  } ma_status_t;

  typedef struct packed {
    logic [CAN_ID_W-1:0]   id;
    logic [3:0]            dlc;
    logic [CAN_DATA_W-1:0] data;
  } can_frame_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_CFM
  } txq_state_e;

  // Classic CAN codes 9..15 still mean eight data bytes.
  function automatic logic [3:0] clamp_dlc(input logic [3:0] dlc);
    return (dlc > 4'(CAN_MAX_DLC)) ? 4'(CAN_MAX_DLC) : dlc;
  endfunction

endpackage

// File: rtl/can_frame_fifo.sv
// Synchronous FIFO of CAN frames with a flush that can optionally
// preserve the head entry (the frame currently on the bus).
module can_frame_fifo
  import can_mac_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  can_frame_t               wr_frame_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic                     keep_head_i,
  output can_frame_t               head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  can_frame_t      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      // A head completing in the same cycle as a keep-head flush leaves nothing behind.
      if (keep_head_i && !pop_i && count_q != '0) begin
        wr_ptr_d = rd_ptr_q + 1'b1;
        count_d  = CW'(1);
      end else begin
        rd_ptr_d = pop_i ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = rd_ptr_d;
        count_d  = '0;
      end
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wr_frame_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/can_tx_msg_queue.sv
// CAN transmit queue: buffers host frames, issues them to the MAC one at a
// time, retries failed attempts and reports per-frame outcome pulses.
module can_tx_msg_queue
  import can_mac_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int MAX_RETRY = 3,
  parameter int DATA_W    = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic [10:0]            host_id,
  input  logic [3:0]             host_dlc,
  input  logic [DATA_W-1:0]      host_data,
  input  logic                   flush,
  output logic                   ma_req_valid,
  input  logic                   ma_req_ready,
  output logic [10:0]            ma_req_identifier,
  output logic [3:0]             ma_req_dlc,
  output logic [DATA_W-1:0]      ma_req_data_payload,
  input  logic                   ma_cfm_valid,
  output logic                   ma_cfm_ready,
  input  logic [10:0]            ma_cfm_identifier,
  input  ma_status_t             ma_cfm_status,
  output logic                   tx_ok,
  output logic                   tx_drop,
  output logic                   id_mismatch,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  txq_state_e     state_q, state_d;
  logic [RW-1:0]  retry_q, retry_d;
  logic           tx_ok_q, tx_ok_d;
  logic           tx_drop_q, tx_drop_d;
  logic           mismatch_q, mismatch_d;

  can_frame_t     wr_frame, head;
  logic [CW-1:0]  fifo_count;
  logic           push, pop, req_hs, cfm_hs, keep_head;

  assign host_ready = (fifo_count != CW'(DEPTH));
  assign push       = host_valid && host_ready && !flush;

  assign wr_frame.id   = host_id;
  assign wr_frame.dlc  = clamp_dlc(host_dlc);
  assign wr_frame.data = host_data;

  assign req_hs    = (state_q == ST_REQ) && ma_req_ready;
  assign cfm_hs    = (state_q == ST_WAIT_CFM) && ma_cfm_valid;
  // Once the MAC has taken the request, the head is on the bus and must survive a flush.
  assign keep_head = (state_q == ST_WAIT_CFM) || req_hs;

  can_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .wr_frame_i  (wr_frame),
    .pop_i       (pop),
    .flush_i     (flush),
    .keep_head_i (keep_head),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    pop        = 1'b0;
    tx_ok_d    = 1'b0;
    tx_drop_d  = 1'b0;
    mismatch_d = mismatch_q;
    case (state_q)
      ST_IDLE: begin
        if (!flush && fifo_count != '0) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (req_hs) begin
          state_d = ST_WAIT_CFM;
        end else if (flush) begin
          state_d = ST_IDLE;
          retry_d = '0;
        end
      end
      ST_WAIT_CFM: begin
        if (cfm_hs) begin
          if (ma_cfm_status == Success) begin
            pop     = 1'b1;
            tx_ok_d = 1'b1;
            retry_d = '0;
            state_d = ST_IDLE;
          end else if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_REQ;
          end else begin
            pop       = 1'b1;
            tx_drop_d = 1'b1;
            retry_d   = '0;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) mismatch_d = 1'b0;
    if (cfm_hs && ma_cfm_identifier != head.id) mismatch_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      retry_q    <= '0;
      tx_ok_q    <= 1'b0;
      tx_drop_q  <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      tx_ok_q    <= tx_ok_d;
      tx_drop_q  <= tx_drop_d;
      mismatch_q <= mismatch_d;
    end
  end

  // Request fields are forced to zero while idle so an empty FIFO never leaks stale data.
  assign ma_req_valid        = (state_q == ST_REQ);
  assign ma_req_identifier   = ma_req_valid ? head.id   : '0;
  assign ma_req_dlc          = ma_req_valid ? head.dlc  : '0;
  assign ma_req_data_payload = ma_req_valid ? head.data : '0;
  assign ma_cfm_ready        = (state_q == ST_WAIT_CFM);
  assign tx_ok               = tx_ok_q;
  assign tx_drop             = tx_drop_q;
  assign id_mismatch         = mismatch_q;
  assign count               = fifo_count;

endmodule

// File: tb/tb_can_tx_msg_queue.sv
// Scoreboard bench for can_tx_msg_queue: a frame-list reference model checks
// every request, confirm outcome, pulse and occupancy against a randomized MAC.
`timescale 1ns/1ps
module tb_can_tx_msg_queue;
  import can_mac_pkg::*;

  localparam int DEPTH     = 8;
  localparam int MAX_RETRY = 3;
  localparam int DATA_W    = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic host_valid, host_ready, flush;
  logic [10:0] host_id;
  logic [3:0] host_dlc;
  logic [DATA_W-1:0] host_data;
  logic ma_req_valid, ma_req_ready;
  logic [10:0] ma_req_identifier;
  logic [3:0] ma_req_dlc;
  logic [DATA_W-1:0] ma_req_data_payload;
  logic ma_cfm_valid, ma_cfm_ready;
  logic [10:0] ma_cfm_identifier;
  ma_status_t ma_cfm_status;
  logic tx_ok, tx_drop, id_mismatch;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  can_tx_msg_queue #(.DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_valid(host_valid), .host_ready(host_ready), .host_id(host_id),
    .host_dlc(host_dlc), .host_data(host_data), .flush(flush),
    .ma_req_valid(ma_req_valid), .ma_req_ready(ma_req_ready),
    .ma_req_identifier(ma_req_identifier), .ma_req_dlc(ma_req_dlc),
    .ma_req_data_payload(ma_req_data_payload),
    .ma_cfm_valid(ma_cfm_valid), .ma_cfm_ready(ma_cfm_ready),
    .ma_cfm_identifier(ma_cfm_identifier), .ma_cfm_status(ma_cfm_status),
    .tx_ok(tx_ok), .tx_drop(tx_drop), .id_mismatch(id_mismatch), .count(count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue is just an ordered list of frames.
  typedef struct { logic [10:0] id; logic [3:0] dlc; logic [63:0] data; } frm_t;
  frm_t mq[$];
  frm_t h;
  bit   m_inflight, m_mis, exp_ok, exp_drop;
  int   m_retry;
  int   sz;
  bit   wait_st, popped, mis_set;
  bit   req_hs_s, cfm_hs_s, prev_stall;
  logic [10:0] hs_id_s, prev_id;
  logic [3:0]  prev_dlc;
  logic [63:0] prev_data;
  int   hs_count = 0, n_ok_obs = 0, n_drop_obs = 0;

  // MAC responder controls, written by the main sequence only.
  int   ready_mode, dly_min, dly_max;
  bit   corrupt, rand_status;
  ma_status_t script[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_inflight = 0; m_mis = 0; m_retry = 0;
      exp_ok = 0; exp_drop = 0;
      req_hs_s = 0; cfm_hs_s = 0; prev_stall = 0;
    end else begin
      sz = mq.size();
      popped = 0; mis_set = 0;
      chk("count", count, sz);
      chk("host_ready", host_ready, sz != DEPTH);
      chk("cfm_ready", ma_cfm_ready, m_inflight);
      chk("tx_ok", tx_ok, exp_ok);
      chk("tx_drop", tx_drop, exp_drop);
      chk("id_mismatch", id_mismatch, m_mis);
      if (tx_ok) n_ok_obs++;
      if (tx_drop) n_drop_obs++;
      if (prev_stall) begin
        chk("req_hold_valid", ma_req_valid, 1);
        chk("req_hold_id_dlc", {ma_req_identifier, ma_req_dlc}, {prev_id, prev_dlc});
        chk("req_hold_data", ma_req_data_payload, prev_data);
      end
      req_hs_s = ma_req_valid && ma_req_ready;
      cfm_hs_s = ma_cfm_valid && ma_cfm_ready;
      exp_ok = 0; exp_drop = 0;
      wait_st = m_inflight || req_hs_s;
      if (req_hs_s) begin
        hs_count++;
        hs_id_s = ma_req_identifier;
        if (sz == 0) begin
          checks++; errors++;
          $display("FAIL req_unexpected: got id 0x%0h expected no request at %0t", ma_req_identifier, $time);
        end else begin
          chk("req_id", ma_req_identifier, mq[0].id);
          chk("req_dlc", ma_req_dlc, mq[0].dlc);
          chk("req_data", ma_req_data_payload, mq[0].data);
        end
        m_inflight = 1;
      end
      if (cfm_hs_s && mq.size() != 0) begin
        if (ma_cfm_identifier != mq[0].id) mis_set = 1;
        m_inflight = 0;
        if (ma_cfm_status == Success) begin
          void'(mq.pop_front()); popped = 1; exp_ok = 1; m_retry = 0;
        end else if (m_retry < MAX_RETRY) begin
          m_retry++;
        end else begin
          void'(mq.pop_front()); popped = 1; exp_drop = 1; m_retry = 0;
        end
      end
      if (flush) begin
        if (wait_st && !popped) begin
          h = mq[0]; mq.delete(); mq.push_back(h);
        end else begin
          mq.delete();
          if (!wait_st) m_retry = 0;
        end
        m_mis = 0;
      end
      if (mis_set) m_mis = 1;
      if (host_valid && !flush && sz < DEPTH) begin
        h.id = host_id;
        h.dlc = (host_dlc > 4'd8) ? 4'd8 : host_dlc;
        h.data = host_data;
        mq.push_back(h);
      end
      prev_stall = ma_req_valid && !ma_req_ready && !flush;
      prev_id = ma_req_identifier; prev_dlc = ma_req_dlc; prev_data = ma_req_data_payload;
    end
  end

  // MAC responder: acts just after each edge on the handshakes the model saw.
  bit pend;
  int dly;
  initial begin
    ma_req_ready = 0; ma_cfm_valid = 0; ma_cfm_identifier = '0; ma_cfm_status = Success;
    pend = 0; dly = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        ma_req_ready = 0; ma_cfm_valid = 0; pend = 0;
      end else begin
        if (cfm_hs_s) ma_cfm_valid = 0;
        if (req_hs_s) begin
          pend = 1;
          dly = $urandom_range(dly_max, dly_min);
        end
        if (pend) begin
          if (dly == 0) begin
            ma_cfm_valid = 1;
            ma_cfm_identifier = corrupt ? 11'h7FF : hs_id_s;
            if (script.size() != 0) ma_cfm_status = script.pop_front();
            else if (rand_status) ma_cfm_status = ($urandom_range(0, 2) == 0) ? Fail : Success;
            else ma_cfm_status = Success;
            pend = 0;
          end else dly--;
        end
        case (ready_mode)
          0: ma_req_ready = 0;
          1: ma_req_ready = 1;
          default: ma_req_ready = 1'($urandom_range(0, 1));
        endcase
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] d);
    host_valid = 1; host_id = id; host_dlc = dlc; host_data = d;
    cyc();
    host_valid = 0;
  endtask

  task automatic pulse_flush();
    flush = 1; cyc(); flush = 0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((mq.size() != 0 || m_inflight || ma_cfm_valid) && n < budget) begin
      cyc(); n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: got %0d frames left expected 0 within %0d cycles", name, mq.size(), budget);
    end
    repeat (3) cyc();
  endtask

  int b_ok, b_drop, b_hs, n;

  initial begin
    host_valid = 0; host_id = '0; host_dlc = '0; host_data = '0; flush = 0;
    ready_mode = 1; dly_min = 0; dly_max = 0; corrupt = 0; rand_status = 0;
    #12;
    chk("rst_host_ready", host_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_req_valid", ma_req_valid, 0);
    chk("rst_cfm_ready", ma_cfm_ready, 0);
    chk("rst_pulses", {tx_ok, tx_drop, id_mismatch}, 0);
    @(posedge clk); #2 rst_n = 1;
    cyc();

    // single frame, latency to request
    b_ok = n_ok_obs;
    push(11'h123, 4'd4, 64'hDEADBEEF_00000000);
    @(negedge clk);
    chk("lat_edge1_valid", ma_req_valid, 0);
    chk("lat_count1", count, 1);
    @(negedge clk);
    chk("lat_edge2_valid", ma_req_valid, 1);
    chk("single_id", ma_req_identifier, 11'h123);
    chk("single_dlc", ma_req_dlc, 4);
    chk("single_data", ma_req_data_payload, 64'hDEADBEEF_00000000);
    cyc();
    wait_drain("single_drain", 50);
    chk("single_ok_pulses", n_ok_obs - b_ok, 1);
    chk("single_count0", count, 0);

    // backpressure and ordering, with an oversized DLC
    b_ok = n_ok_obs; b_hs = hs_count;
    ready_mode = 0;
    push(11'h100, 4'd15, 64'h0102030405060708);
    push(11'h101, 4'd2, 64'hA5A5_0000_0000_0000);
    push(11'h102, 4'd8, 64'hFFFF_EEEE_DDDD_CCCC);
    repeat (20) cyc();
    chk("bp_count", count, 3);
    chk("bp_no_hs", hs_count - b_hs, 0);
    ready_mode = 1;
    wait_drain("bp_drain", 100);
    chk("bp_ok_pulses", n_ok_obs - b_ok, 3);
    chk("bp_requests", hs_count - b_hs, 3);

    // retry exhaustion then a clean frame
    b_ok = n_ok_obs; b_drop = n_drop_obs; b_hs = hs_count;
    script = '{Fail, Fail, Fail, Fail};
    push(11'h0AA, 4'd1, 64'h11);
    push(11'h0AB, 4'd1, 64'h22);
    wait_drain("drop_drain", 200);
    chk("drop_requests", hs_count - b_hs, 5);
    chk("drop_pulses", n_drop_obs - b_drop, 1);
    chk("drop_ok_pulses", n_ok_obs - b_ok, 1);
    b_ok = n_ok_obs; b_drop = n_drop_obs; b_hs = hs_count;
    script = '{Fail, Fail, Success};
    push(11'h0AC, 4'd3, 64'h33);
    wait_drain("retry_drain", 200);
    chk("retry_requests", hs_count - b_hs, 3);
    chk("retry_ok_pulses", n_ok_obs - b_ok, 1);
    chk("retry_drop_pulses", n_drop_obs - b_drop, 0);

    // full queue
    b_ok = n_ok_obs;
    ready_mode = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      host_valid = 1; host_id = 11'(11'h200 + i); host_dlc = 4'(i % 9); host_data = {$urandom, $urandom};
      cyc();
    end
    host_valid = 0;
    chk("full_ready", host_ready, 0);
    chk("full_count", count, DEPTH);
    ready_mode = 1;
    n = 0;
    while (count == 4'(DEPTH) && n < 40) begin cyc(); n++; end
    chk("full_pop_ready", host_ready, 1);
    wait_drain("full_drain", 300);
    chk("full_ok_pulses", n_ok_obs - b_ok, DEPTH);

    // flush while a frame is awaiting confirmation
    b_ok = n_ok_obs; b_hs = hs_count;
    dly_min = 8; dly_max = 8;
    for (int i = 0; i < 5; i++) push(11'(11'h300 + i), 4'd8, {$urandom, $urandom});
    n = 0;
    while (!ma_cfm_ready && n < 20) begin cyc(); n++; end
    pulse_flush();
    @(negedge clk);
    chk("flush_count1", count, 1);
    cyc();
    wait_drain("flush_drain", 100);
    chk("flush_ok_pulses", n_ok_obs - b_ok, 1);
    chk("flush_requests", hs_count - b_hs, 1);
    chk("flush_count0", count, 0);

    // identifier mismatch is sticky until flush
    dly_min = 0; dly_max = 2;
    corrupt = 1;
    push(11'h123, 4'd2, 64'h55);
    wait_drain("mis_drain", 50);
    corrupt = 0;
    chk("mis_set", id_mismatch, 1);
    push(11'h124, 4'd2, 64'h66);
    wait_drain("mis_drain2", 50);
    chk("mis_sticky", id_mismatch, 1);
    pulse_flush();
    @(negedge clk);
    chk("mis_cleared", id_mismatch, 0);
    cyc();

    // randomized traffic
    ready_mode = 2; rand_status = 1; dly_min = 0; dly_max = 3;
    for (int i = 0; i < 400; i++) begin
      host_valid = 1'($urandom_range(0, 1));
      host_id = 11'($urandom); host_dlc = 4'($urandom); host_data = {$urandom, $urandom};
      flush = ($urandom_range(0, 39) == 0);
      corrupt = ($urandom_range(0, 7) == 0);
      cyc();
    end
    host_valid = 0; flush = 0; corrupt = 0;
    wait_drain("rand_drain", 1000);
    chk("rand_count0", count, 0);

    // asynchronous reset in the middle of a request
    rand_status = 0; ready_mode = 0;
    corrupt = 1; push(11'h050, 4'd1, 64'h1); ready_mode = 1;
    wait_drain("pre_rst_drain", 50);
    corrupt = 0; ready_mode = 0;
    push(11'h055, 4'd5, 64'hCAFE);
    n = 0;
    while (!ma_req_valid && n < 10) begin cyc(); n++; end
    chk("rst_mid_req_seen", ma_req_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_host_ready", host_ready, 1);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_req", {ma_req_valid, ma_req_identifier, ma_req_dlc}, 0);
    chk("rst_mid_data", ma_req_data_payload, 0);
    chk("rst_mid_outs", {ma_cfm_ready, tx_ok, tx_drop, id_mismatch}, 0);
    @(posedge clk); #2 rst_n = 1;
    cyc();
    b_hs = hs_count; b_ok = n_ok_obs; b_drop = n_drop_obs;
    ready_mode = 1;
    repeat (10) cyc();
    chk("post_rst_no_req", hs_count - b_hs, 0);
    chk("post_rst_no_pulse", (n_ok_obs - b_ok) + (n_drop_obs - b_drop), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
